// File: rtl/bp_layer_scheduler_if.sv
// Handshake bundle between the training controller (master) and the
// back-propagation layer scheduler (slave).
interface bp_layer_scheduler_if #(
    parameter int NUM_LAYERS  = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int EPOCH_WIDTH = 16
);
    logic                   i_train_req;
    logic                   i_abort;
    logic [NUM_LAYERS-1:0]  i_layer_done;
    logic [NUM_LAYERS-1:0]  o_layer_valid;
    logic [SEL_WIDTH-1:0]   o_layer_sel;
    logic                   o_train_ack;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_error;
    logic [SEL_WIDTH-1:0]   o_err_layer;
    logic [EPOCH_WIDTH-1:0] o_epoch_count;

    modport master (
        output i_train_req, i_abort, i_layer_done,
        input  o_layer_valid, o_layer_sel, o_train_ack, o_busy, o_done,
               o_error, o_err_layer, o_epoch_count
    );

    modport slave (
        input  i_train_req, i_abort, i_layer_done,
        output o_layer_valid, o_layer_sel, o_train_ack, o_busy, o_done,
               o_error, o_err_layer, o_epoch_count
    );
endinterface

// File: rtl/bp_layer_scheduler.sv
// Sequences one back-propagation pass: starts each layer engine from the output
// layer down to layer 0, waits for its completion and guards it with a timeout.
module bp_layer_scheduler #(
    parameter int NUM_LAYERS     = 3,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMER_WIDTH    = 13,
    parameter int EPOCH_WIDTH    = 16
) (
    input logic clk,
    input logic rst_n,
    bp_layer_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [SEL_WIDTH-1:0]   LAST_SEL  = SEL_WIDTH'(NUM_LAYERS - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
    logic [SEL_WIDTH-1:0]   err_layer_q, err_layer_d;
    logic [NUM_LAYERS-1:0]  layer_valid_q, layer_valid_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d       = state_q;
        sel_d         = sel_q;
        timer_d       = timer_q;
        epoch_d       = epoch_q;
        err_layer_d   = err_layer_q;
        layer_valid_d = '0;
        ack_d         = 1'b0;
        done_d        = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_train_req) begin
                    state_d = S_ISSUE;
                    sel_d   = LAST_SEL;
                    ack_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // A completion on the timeout edge is accepted: done outranks the timer.
                if (bus.i_abort) begin
                    state_d = S_IDLE;
                    sel_d   = LAST_SEL;
                end else if (bus.i_layer_done[sel_q]) begin
                    if (sel_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        epoch_d = epoch_q + EPOCH_WIDTH'(1);
                    end else begin
                        state_d = S_ISSUE;
                        sel_d   = sel_q - SEL_WIDTH'(1);
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d     = S_ERR;
                    error_d     = 1'b1;
                    err_layer_d = sel_q;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                sel_d   = LAST_SEL;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = LAST_SEL;
            end
        endcase

        if (state_d == S_ISSUE) begin
            layer_valid_d = NUM_LAYERS'(1) << sel_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Reset is synchronous and asserted when rst_n is HIGH, matching the training controller.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= LAST_SEL;
            timer_q       <= '0;
            epoch_q       <= '0;
            err_layer_q   <= '0;
            layer_valid_q <= '0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            epoch_q       <= epoch_d;
            err_layer_q   <= err_layer_d;
            layer_valid_q <= layer_valid_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.o_layer_valid = layer_valid_q;
    assign bus.o_layer_sel   = sel_q;
    assign bus.o_train_ack   = ack_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_error       = error_q;
    assign bus.o_err_layer   = err_layer_q;
    assign bus.o_epoch_count = epoch_q;
endmodule

// File: tb/tb_bp_layer_scheduler.sv
// Directed bench for bp_layer_scheduler: a vector table for a full pass plus
// hand-written timeout, abort, reset and back-to-back/wrap sequences.
module tb_bp_layer_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_layer_scheduler_if #(.NUM_LAYERS(3), .SEL_WIDTH(2), .EPOCH_WIDTH(2)) bus ();

    bp_layer_scheduler #(
        .NUM_LAYERS    (3),
        .SEL_WIDTH     (2),
        .TIMEOUT_CYCLES(8),
        .TIMER_WIDTH   (4),
        .EPOCH_WIDTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic       rst, req, abort;
        logic [2:0] done;
        logic [2:0] v;
        logic [1:0] sel;
        logic       ack, busy, dn, err;
        logic [1:0] el, ep;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic r, q, a, input logic [2:0] d,
                                input logic [2:0] v, input logic [1:0] s,
                                input logic ak, b, dn, e, input logic [1:0] el, ep);
        mk = {r, q, a, d, v, s, ak, b, dn, e, el, ep};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {valid,sel,ack,busy,done,err,err_layer,epoch}=%b expected %b",
                     name, act, exp);
        end
    endtask

    // Drive one set of inputs, let one edge sample them, then settle before checking.
    task automatic cyc(input logic r, q, a, input logic [2:0] d);
        rst_n            = r;
        bus.i_train_req  = q;
        bus.i_abort      = a;
        bus.i_layer_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [2:0] v, input logic [1:0] s,
                              input logic ak, b, dn, e, input logic [1:0] el, ep);
        check(name, {bus.o_layer_valid, bus.o_layer_sel, bus.o_train_ack, bus.o_busy,
                     bus.o_done, bus.o_error, bus.o_err_layer, bus.o_epoch_count},
              {v, s, ak, b, dn, e, el, ep});
    endtask

    initial begin
        rst_n            = 1'b1;
        bus.i_train_req  = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_layer_done = '0;

        // Full pass, done 3 cycles after each start; req held, stray dones injected.
        tbl[0]  = mk(1, 0, 0, 3'b000, 3'b000, 2, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 3'b000, 3'b100, 2, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 3'b100, 3'b000, 2, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 3'b001, 3'b000, 2, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 3'b000, 3'b000, 2, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 3'b100, 3'b010, 1, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 3'b100, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 3'b000, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 3'b010, 3'b001, 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 3'b001, 3'b000, 0, 0, 1, 1, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 3'b000, 3'b000, 2, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].req, tbl[i].abort, tbl[i].done);
            expect_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].sel, tbl[i].ack,
                       tbl[i].busy, tbl[i].dn, tbl[i].err, tbl[i].el, tbl[i].ep);
        end

        // Layer 1 never completes: error after its 8th WAIT cycle.
        cyc(0, 1, 0, 3'b000); expect_out("to_ack",   3'b100, 2, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 3'b000); expect_out("to_w2",    3'b000, 2, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 3'b100); expect_out("to_iss1",  3'b010, 1, 0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 3'b000);
            expect_out($sformatf("to_wait%0d", k), 3'b000, 1, 0, 1, 0, 0, 0, 1);
        end
        cyc(0, 0, 0, 3'b000); expect_out("to_err",   3'b000, 1, 0, 1, 0, 1, 1, 1);
        cyc(0, 0, 0, 3'b000); expect_out("to_idle",  3'b000, 2, 0, 0, 0, 0, 1, 1);

        // Done on the timeout edge wins.
        cyc(0, 1, 0, 3'b000); expect_out("co_ack",   3'b100, 2, 1, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 3'b000); expect_out("co_w2",    3'b000, 2, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 3'b100); expect_out("co_iss1",  3'b010, 1, 0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 3'b000);
            expect_out($sformatf("co_wait%0d", k), 3'b000, 1, 0, 1, 0, 0, 1, 1);
        end
        cyc(0, 0, 0, 3'b010); expect_out("co_iss0",  3'b001, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 3'b000); expect_out("co_w0",    3'b000, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 0, 0, 3'b001); expect_out("co_done",  3'b000, 0, 0, 1, 1, 0, 1, 2);
        cyc(0, 0, 0, 3'b000); expect_out("co_idle",  3'b000, 2, 0, 0, 0, 0, 1, 2);

        // Abort: ignored in IDLE, held off in ISSUE, taken in WAIT.
        cyc(0, 0, 1, 3'b000); expect_out("ab_idle",  3'b000, 2, 0, 0, 0, 0, 1, 2);
        cyc(0, 1, 0, 3'b000); expect_out("ab_ack",   3'b100, 2, 1, 1, 0, 0, 1, 2);
        cyc(0, 0, 0, 3'b000); expect_out("ab_w2",    3'b000, 2, 0, 1, 0, 0, 1, 2);
        cyc(0, 0, 0, 3'b100); expect_out("ab_iss1",  3'b010, 1, 0, 1, 0, 0, 1, 2);
        cyc(0, 0, 1, 3'b000); expect_out("ab_hold",  3'b000, 1, 0, 1, 0, 0, 1, 2);
        cyc(0, 0, 1, 3'b000); expect_out("ab_taken", 3'b000, 2, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 3'b000); expect_out("ab_quiet", 3'b000, 2, 0, 0, 0, 0, 1, 2);

        // Reset mid-pass clears counters and produces no pulse.
        cyc(0, 1, 0, 3'b000); expect_out("rs_ack",   3'b100, 2, 1, 1, 0, 0, 1, 2);
        cyc(0, 0, 0, 3'b000); expect_out("rs_w2",    3'b000, 2, 0, 1, 0, 0, 1, 2);
        cyc(1, 0, 0, 3'b100); expect_out("rs_reset", 3'b000, 2, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 3'b000); expect_out("rs_quiet", 3'b000, 2, 0, 0, 0, 0, 0, 0);

        // req held high: minimum-length back-to-back passes, epoch wraps 1,2,3,0.
        for (int p = 0; p < 4; p++) begin
            logic [1:0] ep0, ep1;
            ep0 = 2'(p);
            ep1 = 2'(p + 1);
            cyc(0, 1, 0, 3'b000); expect_out($sformatf("bb%0d_ack", p),  3'b100, 2, 1, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b100); expect_out($sformatf("bb%0d_w2", p),   3'b000, 2, 0, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b100); expect_out($sformatf("bb%0d_i1", p),   3'b010, 1, 0, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b000); expect_out($sformatf("bb%0d_w1", p),   3'b000, 1, 0, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b010); expect_out($sformatf("bb%0d_i0", p),   3'b001, 0, 0, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b000); expect_out($sformatf("bb%0d_w0", p),   3'b000, 0, 0, 1, 0, 0, 0, ep0);
            cyc(0, 1, 0, 3'b001); expect_out($sformatf("bb%0d_done", p), 3'b000, 0, 0, 1, 1, 0, 0, ep1);
            cyc(0, 1, 0, 3'b000); expect_out($sformatf("bb%0d_gap", p),  3'b000, 2, 0, 0, 0, 0, 0, ep1);
        end
        cyc(0, 0, 0, 3'b000); expect_out("bb_end", 3'b000, 2, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
